seg7_pair_decoder: RTL and testbench
====================================

# seg7_pair_decoder

Receive-side counterpart of the two-digit calculator display path: watches the tens/units seven-segment buses (D1, D0), waits until the pattern is stable, and decodes it back to BCD digits and a binary value 0..99. Each new stable reading goes out on a valid/ready handshake. It sits in the self-check and loopback path beside the calculator top, so displayed results can be compared against expected products without a human reading LEDs.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples needed before a reading is accepted; legal range 1..15.
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- D1  input  7  tens-digit segments, active-high, bit order {g,f,e,d,c,b,a} (bit0 = a).
- D0  input  7  units-digit segments, same encoding as D1.
- out_valid  output  1  a decoded reading is presented.
- out_ready  input  1  consumer accepts the reading.
- tens  output  4  decoded tens digit, 0..9; 4'hF if D1 is illegal.
- units  output  4  decoded units digit, 0..9; 4'hF if D0 is illegal.
- value  output  7  tens*10+units, 0..99; 0 when err=1.
- err  output  1  at least one digit pattern is not a legal 0..9 glyph.

## Operation
- Legal glyphs (hex, bit6..bit0):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Anything else is illegal, including blank 00 and the alternate 6/9/7 forms.
- Input stage:
  - {D1,D0} registered every clock into a 14-bit sample.
  - A stability counter clears on any change of the sample, increments otherwise, and saturates at STABLE_CYCLES.
- Last-reported register:
  - Holds the 14-bit pattern most recently transferred.
  - Has a "none" flag that is set by reset.
- FSM states:
  - WAIT to PRESENT: the counter has reached STABLE_CYCLES, and the sample differs from last-reported or "none" is set.
    - On that transition, capture the decoded tens/units/value/err into the output registers.
  - PRESENT: outputs are frozen while out_valid=1 and out_ready=0.
  - PRESENT to WAIT: on the edge where out_valid&&out_ready.
    - last-reported <= the captured pattern; clear "none".
- Backpressure: input changes during PRESENT are not captured.
  - After the transfer, the current input is evaluated normally.
  - If it is already stable and different, it is presented on the next eligible edge.
- Illegal patterns still go through the handshake, with err=1 and value=0.
- Widths: value = tens*10 + units, computed in 7 bits; no overflow is possible for legal digits.

## Timing
- Reset values:
  - out_valid=0, tens=0, units=0, value=0, err=0.
  - Sample=0, counter=0, state=WAIT, "none"=1.
- Reset takes effect on the edge it is sampled.
  - A pending reading is discarded.
  - out_ready is ignored while rst=1.
- Latency: with {D1,D0} constant from before edge k, out_valid rises after edge k+STABLE_CYCLES if the reading is eligible.
- Handshake:
  - Transfer occurs on an edge with out_valid&&out_ready.
  - out_valid goes low after that edge.
  - There are at least 2 cycles between successive out_valid assertions.
- A change on either bus at any point in WAIT restarts the stability count.
- A pattern equal to last-reported is never re-reported until reset.

## Structure
- Package seg7_pkg holds:
  - SEG_0..SEG_9 and SEG_BLANK constants.
  - The digit typedef (logic [3:0]) and DIGIT_ERR = 4'hF.
  - The FSM state enum {WAIT, PRESENT}.
- Sub-module seg7_digit_decode: combinational, 7-bit segments in, 4-bit digit plus illegal flag out; instantiated twice.
- The top holds the sampling register, stability counter, last-reported register, FSM and output registers.

## Test plan
All scenarios use STABLE_CYCLES=4.
- Reset, then D1=3F, D0=3F held with out_ready=1:
  - out_valid rises 4 edges after the sample edge, with tens=0, units=0, value=0, err=0.
  - out_valid stays high one cycle and never re-asserts.
- D1=4F, D0=5B held (the "32" that the display shows for 12*11) → value=32, tens=3, units=2.
- From stable 32, drive D1=7D, D0=7F for 2 cycles, then back to 32 → no out_valid.
- out_ready=0, present 45 (66/6D) until out_valid=1, then change the inputs to 72 (07/5B) and hold:
  - Outputs stay at 45 until out_ready=1.
  - After the transfer, 72 is presented on the next eligible edge.
- D1=00, D0=06 held → err=1, tens=F, units=1, value=0; the handshake completes normally.
- With out_valid pending at value 15, pulse rst for one cycle:
  - All outputs are 0 after that edge.
  - The unchanged pattern 15 is reported again 4 edges after rst drops.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment pair decoder.
package seg7_pkg;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef logic [3:0] digit_t;
    localparam digit_t DIGIT_ERR = 4'hF;

    typedef enum logic {WAIT, PRESENT} state_t;

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational decode of one seven-segment glyph back to a BCD digit.
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output digit_t     o_digit,
    output logic       o_illegal
);

    // Only the canonical glyphs map to digits; blank and alternate forms are illegal
    always_comb begin
        o_digit   = DIGIT_ERR;
        o_illegal = 1'b0;
        case (i_seg)
            SEG_0:   o_digit = 4'd0;
            SEG_1:   o_digit = 4'd1;
            SEG_2:   o_digit = 4'd2;
            SEG_3:   o_digit = 4'd3;
            SEG_4:   o_digit = 4'd4;
            SEG_5:   o_digit = 4'd5;
            SEG_6:   o_digit = 4'd6;
            SEG_7:   o_digit = 4'd7;
            SEG_8:   o_digit = 4'd8;
            SEG_9:   o_digit = 4'd9;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_pair_decoder.sv
// Two-digit seven-segment reader: debounces {D1,D0}, decodes to BCD and
// binary, and hands each new stable reading out on a valid/ready handshake.
module seg7_pair_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] D1,
    input  logic [6:0] D0,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic [6:0] value,
    output logic       err
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);

    logic [13:0] r_sample;
    logic [3:0]  r_cnt;
    logic [13:0] r_last;
    logic        r_none;
    logic [13:0] r_cap;
    state_t      r_state;

    logic        w_same;
    logic [3:0]  w_cnt_nxt;
    digit_t      w_tens;
    digit_t      w_units;
    logic        w_ill1;
    logic        w_ill0;
    logic        w_err;
    logic [6:0]  w_value;
    logic        w_eligible;

    // Decode the registered sample, not the raw pins, so capture matches what was debounced
    seg7_digit_decode u_dec_tens (
        .i_seg     (r_sample[13:7]),
        .o_digit   (w_tens),
        .o_illegal (w_ill1)
    );

    seg7_digit_decode u_dec_units (
        .i_seg     (r_sample[6:0]),
        .o_digit   (w_units),
        .o_illegal (w_ill0)
    );

    // Next count is used for the decision so a reading is accepted on the
    // same edge the counter reaches STABLE_CYCLES
    always_comb begin
        w_same     = ({D1, D0} == r_sample);
        w_cnt_nxt  = 4'd0;
        if (w_same)
            w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 4'd1;
        w_err      = w_ill1 | w_ill0;
        w_value    = w_err ? 7'd0 : (7'(w_tens) * 7'd10 + 7'(w_units));
        w_eligible = (w_cnt_nxt == CNT_MAX) && (r_none || (r_sample != r_last));
    end

    // Input sampling and saturating stability counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample <= 14'd0;
            r_cnt    <= 4'd0;
        end else begin
            r_sample <= {D1, D0};
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Handshake FSM with registered outputs; outputs freeze while PRESENT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= WAIT;
            out_valid <= 1'b0;
            tens      <= 4'd0;
            units     <= 4'd0;
            value     <= 7'd0;
            err       <= 1'b0;
            r_cap     <= 14'd0;
            r_last    <= 14'd0;
            r_none    <= 1'b1;
        end else begin
            case (r_state)
                WAIT: begin
                    if (w_eligible) begin
                        r_state   <= PRESENT;
                        out_valid <= 1'b1;
                        tens      <= w_tens;
                        units     <= w_units;
                        value     <= w_value;
                        err       <= w_err;
                        r_cap     <= r_sample;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        r_state   <= WAIT;
                        out_valid <= 1'b0;
                        r_last    <= r_cap;
                        r_none    <= 1'b0;
                    end
                end
                default: r_state <= WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_pair_decoder.sv
// Directed self-checking bench for seg7_pair_decoder (STABLE_CYCLES=4).
module tb_seg7_pair_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] D1, D0;
    logic       out_valid, out_ready;
    logic [3:0] tens, units;
    logic [6:0] value;
    logic       err;

    int errors = 0;
    int checks = 0;

    seg7_pair_decoder #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .D1        (D1),
        .D0        (D0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tens      (tens),
        .units     (units),
        .value     (value),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs and outputs are handled 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1; D1 = 7'h00; D0 = 7'h00;
        step();
        checks++;
        if ({out_valid, tens, units, value, err} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b t=%h u=%h val=%0d e=%b, expected all 0",
                     out_valid, tens, units, value, err);
        end
    endtask

    // 00 after reset: exact 4-edge latency, single-cycle valid, no re-report
    task automatic test_zero();
        int seen;
        rst = 1'b0; D1 = 7'h3F; D0 = 7'h3F; out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL zero_early_valid: got %0d early valid cycles, expected 0", seen);
        end
        step();
        checks++;
        if ({out_valid, tens, units, value, err} !== {1'b1, 4'd0, 4'd0, 7'd0, 1'b0}) begin
            errors++;
            $display("FAIL zero_present: got v=%b t=%h u=%h val=%0d e=%b, expected v=1 t=0 u=0 val=0 e=0",
                     out_valid, tens, units, value, err);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL zero_rereport: got %0d valid cycles after transfer, expected 0", seen);
        end
    endtask

    task automatic test_32();
        D1 = 7'h4F; D0 = 7'h5B; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL v32_early: got valid=%b, expected 0", out_valid);
        end
        step();
        checks++;
        if ({out_valid, tens, units, value, err} !== {1'b1, 4'd3, 4'd2, 7'd32, 1'b0}) begin
            errors++;
            $display("FAIL v32_present: got v=%b t=%h u=%h val=%0d e=%b, expected v=1 t=3 u=2 val=32 e=0",
                     out_valid, tens, units, value, err);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL v32_drop: got valid=%b after transfer, expected 0", out_valid);
        end
    endtask

    // Short glitch to 68 then back to the already-reported 32
    task automatic test_glitch();
        int seen;
        seen = 0;
        D1 = 7'h7D; D0 = 7'h7F;
        for (int i = 0; i < 2; i++) begin
            step();
            if (out_valid) seen++;
        end
        D1 = 7'h4F; D0 = 7'h5B;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL glitch_valid: got %0d valid cycles, expected 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        out_ready = 1'b0; D1 = 7'h66; D0 = 7'h6D;
        for (int i = 0; i < 12 && !out_valid; i++) step();
        checks++;
        if ({out_valid, tens, units, value, err} !== {1'b1, 4'd4, 4'd5, 7'd45, 1'b0}) begin
            errors++;
            $display("FAIL bp45_present: got v=%b t=%h u=%h val=%0d e=%b, expected v=1 t=4 u=5 val=45 e=0",
                     out_valid, tens, units, value, err);
        end
        D1 = 7'h07; D0 = 7'h5B;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if ({out_valid, tens, units, value} !== {1'b1, 4'd4, 4'd5, 7'd45}) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp45_frozen: got %0d cycles not holding 45, expected 0", bad);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp45_drop: got valid=%b after transfer, expected 0", out_valid);
        end
        step();
        checks++;
        if ({out_valid, tens, units, value, err} !== {1'b1, 4'd7, 4'd2, 7'd72, 1'b0}) begin
            errors++;
            $display("FAIL bp72_next: got v=%b t=%h u=%h val=%0d e=%b, expected v=1 t=7 u=2 val=72 e=0",
                     out_valid, tens, units, value, err);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp72_drop: got valid=%b after transfer, expected 0", out_valid);
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b0; D1 = 7'h00; D0 = 7'h06;
        for (int i = 0; i < 12 && !out_valid; i++) step();
        checks++;
        if ({out_valid, tens, units, value, err} !== {1'b1, 4'hF, 4'd1, 7'd0, 1'b1}) begin
            errors++;
            $display("FAIL illegal_present: got v=%b t=%h u=%h val=%0d e=%b, expected v=1 t=f u=1 val=0 e=1",
                     out_valid, tens, units, value, err);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_drop: got valid=%b after transfer, expected 0", out_valid);
        end
    endtask

    // Reset discards a pending 15; the same pattern is reported again afterwards
    task automatic test_reset_pending();
        int seen;
        out_ready = 1'b0; D1 = 7'h06; D0 = 7'h6D;
        for (int i = 0; i < 12 && !out_valid; i++) step();
        checks++;
        if ({out_valid, value} !== {1'b1, 7'd15}) begin
            errors++;
            $display("FAIL rp15_present: got v=%b val=%0d, expected v=1 val=15", out_valid, value);
        end
        rst = 1'b1; out_ready = 1'b1;
        step();
        checks++;
        if ({out_valid, tens, units, value, err} !== 17'd0) begin
            errors++;
            $display("FAIL rp_reset_outputs: got v=%b t=%h u=%h val=%0d e=%b, expected all 0",
                     out_valid, tens, units, value, err);
        end
        rst = 1'b0; out_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rp_early_valid: got %0d early valid cycles, expected 0", seen);
        end
        step();
        checks++;
        if ({out_valid, tens, units, value, err} !== {1'b1, 4'd1, 4'd5, 7'd15, 1'b0}) begin
            errors++;
            $display("FAIL rp15_again: got v=%b t=%h u=%h val=%0d e=%b, expected v=1 t=1 u=5 val=15 e=0",
                     out_valid, tens, units, value, err);
        end
        out_ready = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_32();
        test_glitch();
        test_back_to_back();
        test_illegal();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
